// File: rtl/chnlnk_frame_builder.sv
// -----------------------------------------------------------------------------
// chnlnk_frame_builder
//
// Purpose:
//   Builds the 100-word channel-link frame for the DCFEB readout path from the
//   strobes of the upstream frame FSM and the FIFO word it pops. The frame is
//   96 payload words, a frame-count word, an event-count word, a CRC-16 word
//   and a trailer word. One registered 16-bit word plus per-byte K flags is
//   presented to the serializer every clock. Comma idles fill the gaps and an
//   end-of-event marker is sent on LAST_WRD.
//
// Optional feature:
//   CHNLNK_SEQ_CHECK_EN - when defined, every VALID word's SEQ is compared
//   against an expected index. A mismatch sets the sticky SEQ_ERR flag, and
//   the expected index resyncs to SEQ+1. When undefined, SEQ_ERR is set only
//   by out-of-range indices (SEQ > 99).
//
// Ports:
//   CLK       in   1   system clock
//   RST       in   1   asynchronous, active-high reset
//   VALID     in   1   frame word strobe from frame FSM
//   SEQ       in   7   word index within frame, 0..99
//   CLR_CRC   in   1   re-seed CRC and sequence checker
//   LAST_WRD  in   1   end-of-event pulse
//   DIN       in  16   FIFO word (valid when VALID=1 and SEQ<96)
//   TX_DATA   out 16   word to serializer (registered)
//   TX_K      out  2   per-byte K-char flags, bit0 = low byte (registered)
//   TX_VLD    out  1   high while a frame word is on TX_DATA (registered)
//   FRM_CNT   out 12   frames completed, wraps
//   EVT_CNT   out 12   events completed, wraps
//   SEQ_ERR   out  1   sticky sequence error
// -----------------------------------------------------------------------------
module chnlnk_frame_builder #(
  parameter int          DATA_WORDS = 96,
  parameter logic [15:0] IDLE_WORD  = 16'h50BC,
  parameter logic [15:0] EOE_WORD   = 16'hF7F7,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VALID,
  input  logic [6:0]  SEQ,
  input  logic        CLR_CRC,
  input  logic        LAST_WRD,
  input  logic [15:0] DIN,
  output logic [15:0] TX_DATA,
  output logic [1:0]  TX_K,
  output logic        TX_VLD,
  output logic [11:0] FRM_CNT,
  output logic [11:0] EVT_CNT,
  output logic        SEQ_ERR
);

  // Indices of the four overhead words that follow the payload.
  localparam logic [6:0] SEQ_FRM = 7'(DATA_WORDS);
  localparam logic [6:0] SEQ_EVT = 7'(DATA_WORDS + 1);
  localparam logic [6:0] SEQ_CRC = 7'(DATA_WORDS + 2);
  localparam logic [6:0] SEQ_TRL = 7'(DATA_WORDS + 3);

  // CRC-16-CCITT (poly 0x1021), MSB first, whole word in one step.
  function automatic logic [15:0] crc16_ccitt(input logic [15:0] crc,
                                              input logic [15:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) begin
        c = c ^ 16'h1021;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  logic [15:0] crc_r;
  logic [11:0] frm_cnt_r;
  logic [11:0] evt_cnt_r;
  logic        seq_err_r;

  logic        word_acc_s;
  logic [15:0] frame_word_s;
  logic [15:0] tx_data_s;
  logic [1:0]  tx_k_s;
  logic        tx_vld_s;
  logic [15:0] crc_base_s;
  logic [15:0] crc_nxt_s;
  logic [11:0] frm_cnt_nxt_s;
  logic [11:0] evt_cnt_nxt_s;
  logic        seq_err_nxt_s;
  logic        seq_oor_s;

  // LAST_WRD pre-empts VALID, so a word coinciding with it is never sent and
  // must not touch CRC, counters or sequence tracking.
  assign word_acc_s = VALID & ~LAST_WRD;
  assign seq_oor_s  = word_acc_s & (SEQ > SEQ_TRL);

  // Frame word for the current SEQ, ignoring LAST_WRD/VALID qualification.
  always_comb begin
    frame_word_s = DIN;
    if (SEQ == SEQ_FRM) begin
      frame_word_s = {4'hA, frm_cnt_r};
    end else if (SEQ == SEQ_EVT) begin
      frame_word_s = {4'hB, evt_cnt_r};
    end else if (SEQ == SEQ_CRC) begin
      frame_word_s = crc_r;
    end else if (SEQ == SEQ_TRL) begin
      frame_word_s = {4'hC, seq_err_r, 11'h000};
    end else begin
      frame_word_s = DIN;
    end
  end

  // Output word selection in priority order: EOE, frame word, idle comma.
  always_comb begin
    tx_data_s = IDLE_WORD;
    tx_k_s    = 2'b01;
    tx_vld_s  = 1'b0;
    if (LAST_WRD) begin
      tx_data_s = EOE_WORD;
      tx_k_s    = 2'b11;
      tx_vld_s  = 1'b0;
    end else if (VALID) begin
      tx_data_s = frame_word_s;
      tx_k_s    = 2'b00;
      tx_vld_s  = 1'b1;
    end else begin
      tx_data_s = IDLE_WORD;
      tx_k_s    = 2'b01;
      tx_vld_s  = 1'b0;
    end
  end

  // CRC next state: seeding happens first so a word arriving together with
  // CLR_CRC is folded into a fresh CRC_INIT.
  always_comb begin
    crc_base_s = CLR_CRC ? CRC_INIT : crc_r;
    crc_nxt_s  = crc_base_s;
    if (word_acc_s && (SEQ < SEQ_CRC)) begin
      crc_nxt_s = crc16_ccitt(crc_base_s, frame_word_s);
    end else begin
      crc_nxt_s = crc_base_s;
    end
  end

  // Frame/event counters; words 96/97 read the pre-increment register values.
  always_comb begin
    frm_cnt_nxt_s = frm_cnt_r;
    evt_cnt_nxt_s = evt_cnt_r;
    if (word_acc_s && (SEQ == SEQ_TRL)) begin
      frm_cnt_nxt_s = frm_cnt_r + 12'd1;
    end else begin
      frm_cnt_nxt_s = frm_cnt_r;
    end
    if (LAST_WRD) begin
      evt_cnt_nxt_s = evt_cnt_r + 12'd1;
    end else begin
      evt_cnt_nxt_s = evt_cnt_r;
    end
  end

`ifdef CHNLNK_SEQ_CHECK_EN
  logic [6:0] exp_seq_r;
  logic [6:0] exp_base_s;
  logic [6:0] exp_seq_nxt_s;
  logic       seq_mis_s;

  // Expected-index tracker: cleared by CLR_CRC and after the trailer,
  // otherwise resyncs to SEQ+1 on every accepted word.
  always_comb begin
    exp_base_s    = CLR_CRC ? 7'd0 : exp_seq_r;
    seq_mis_s     = word_acc_s & (SEQ != exp_base_s);
    exp_seq_nxt_s = exp_base_s;
    if (word_acc_s) begin
      if (SEQ == SEQ_TRL) begin
        exp_seq_nxt_s = 7'd0;
      end else begin
        exp_seq_nxt_s = SEQ + 7'd1;
      end
    end else begin
      exp_seq_nxt_s = exp_base_s;
    end
    seq_err_nxt_s = seq_err_r | seq_oor_s | seq_mis_s;
  end

  // Expected-index register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_seq_r <= 7'd0;
    end else begin
      exp_seq_r <= exp_seq_nxt_s;
    end
  end
`else
  // Without the checker only out-of-range indices raise the sticky error.
  always_comb begin
    seq_err_nxt_s = seq_err_r | seq_oor_s;
  end
`endif

  // Registered serializer outputs and frame state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TX_DATA   <= IDLE_WORD;
      TX_K      <= 2'b01;
      TX_VLD    <= 1'b0;
      crc_r     <= CRC_INIT;
      frm_cnt_r <= 12'd0;
      evt_cnt_r <= 12'd0;
      seq_err_r <= 1'b0;
    end else begin
      TX_DATA   <= tx_data_s;
      TX_K      <= tx_k_s;
      TX_VLD    <= tx_vld_s;
      crc_r     <= crc_nxt_s;
      frm_cnt_r <= frm_cnt_nxt_s;
      evt_cnt_r <= evt_cnt_nxt_s;
      seq_err_r <= seq_err_nxt_s;
    end
  end

  assign FRM_CNT = frm_cnt_r;
  assign EVT_CNT = evt_cnt_r;
  assign SEQ_ERR = seq_err_r;

endmodule

// File: tb/tb_chnlnk_frame_builder.sv
// -----------------------------------------------------------------------------
// tb_chnlnk_frame_builder
//
// Directed, self-checking bench for chnlnk_frame_builder. Each driven cycle
// pushes the expected output word onto a scoreboard queue; it is popped and
// compared one cycle later. Frame-level checks compare captured words against
// constants and an independent bit-serial CRC-16-CCITT computation.
// Honours CHNLNK_SEQ_CHECK_EN for the sequence-error expectations.
// -----------------------------------------------------------------------------
module tb_chnlnk_frame_builder;

  logic        CLK;
  logic        RST;
  logic        VALID;
  logic [6:0]  SEQ;
  logic        CLR_CRC;
  logic        LAST_WRD;
  logic [15:0] DIN;
  logic [15:0] TX_DATA;
  logic [1:0]  TX_K;
  logic        TX_VLD;
  logic [11:0] FRM_CNT;
  logic [11:0] EVT_CNT;
  logic        SEQ_ERR;

  chnlnk_frame_builder dut (
    .CLK      (CLK),
    .RST      (RST),
    .VALID    (VALID),
    .SEQ      (SEQ),
    .CLR_CRC  (CLR_CRC),
    .LAST_WRD (LAST_WRD),
    .DIN      (DIN),
    .TX_DATA  (TX_DATA),
    .TX_K     (TX_K),
    .TX_VLD   (TX_VLD),
    .FRM_CNT  (FRM_CNT),
    .EVT_CNT  (EVT_CNT),
    .SEQ_ERR  (SEQ_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        v;
  } txw_t;

  txw_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;

  // Reference model state
  logic [15:0] m_crc;
  logic [11:0] m_frm;
  logic [11:0] m_evt;
  logic        m_err;
  logic [6:0]  m_exp;

  logic [15:0] last_tx;
  logic [15:0] fw_obs [0:99];

  // Bit-serial CCITT reference: one bit per iteration.
  function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    c = crc;
    for (int b = 0; b < 16; b++) begin
      if (c[15] != w[15-b]) c = (c << 1) ^ 16'h1021;
      else                  c = (c << 1);
    end
    return c;
  endfunction

  // CRC over a well-formed frame with DIN=SEQ payload.
  function automatic logic [15:0] frame_crc(input logic [11:0] f, input logic [11:0] e);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 96; i++) c = crc_ref(c, 16'(i));
    c = crc_ref(c, {4'hA, f});
    c = crc_ref(c, {4'hB, e});
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_crc = 16'hFFFF;
    m_frm = 12'd0;
    m_evt = 12'd0;
    m_err = 1'b0;
    m_exp = 7'd0;
    sb_q.delete();
  endtask

  // Apply reset asynchronously away from the clock edge and check it acts at once.
  task automatic do_reset();
    RST = 1'b1;
    VALID = 1'b0; SEQ = 7'd0; CLR_CRC = 1'b0; LAST_WRD = 1'b0; DIN = 16'h0000;
    model_reset();
    #1;
    check("rst_tx",  {TX_DATA, TX_K, TX_VLD}, {16'h50BC, 2'b01, 1'b0});
    check("rst_cnt", {FRM_CNT, EVT_CNT, SEQ_ERR}, 25'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drive one cycle, predict its output, then compare one edge later.
  task automatic step(input logic v, input logic [6:0] s, input logic c,
                      input logic l, input logic [15:0] d);
    txw_t        e;
    logic        acc;
    logic [15:0] fw;
    VALID = v; SEQ = s; CLR_CRC = c; LAST_WRD = l; DIN = d;
    if (s == 7'd96)      fw = {4'hA, m_frm};
    else if (s == 7'd97) fw = {4'hB, m_evt};
    else if (s == 7'd98) fw = m_crc;
    else if (s == 7'd99) fw = {4'hC, m_err, 11'h000};
    else                 fw = d;
    if (l)      e = {16'hF7F7, 2'b11, 1'b0};
    else if (v) e = {fw, 2'b00, 1'b1};
    else        e = {16'h50BC, 2'b01, 1'b0};
    sb_q.push_back(e);
    acc = v && !l;
    if (c) m_crc = 16'hFFFF;
    if (acc && s < 7'd98) m_crc = crc_ref(m_crc, fw);
    if (acc && s == 7'd99) m_frm = m_frm + 12'd1;
    if (l) m_evt = m_evt + 12'd1;
    if (acc && s > 7'd99) m_err = 1'b1;
`ifdef CHNLNK_SEQ_CHECK_EN
    if (c) m_exp = 7'd0;
    if (acc) begin
      if (s != m_exp) m_err = 1'b1;
      m_exp = (s == 7'd99) ? 7'd0 : s + 7'd1;
    end
`endif
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    last_tx = TX_DATA;
    check("tx_word", {13'd0, TX_DATA, TX_K, TX_VLD}, {13'd0, e});
    check("counters", {7'd0, FRM_CNT, EVT_CNT, SEQ_ERR}, {7'd0, m_frm, m_evt, m_err});
  endtask

  // CLR_CRC cycle followed by words 0..99 with DIN=SEQ; skip<0 means no skip.
  task automatic frame(input int skip);
    step(1'b0, 7'd0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      if (i != skip) begin
        step(1'b1, 7'(i), 1'b0, 1'b0, 16'(i));
        fw_obs[i] = last_tx;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    VALID = 1'b0; SEQ = 7'd0; CLR_CRC = 1'b0; LAST_WRD = 1'b0; DIN = 16'h0000;
    last_tx = 16'h0000;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 7'd0, 1'b0, 1'b0, 16'h0000);

    // Full frame followed by end of event
    frame(-1);
    check("w96", fw_obs[96], 16'hA000);
    check("w97", fw_obs[97], 16'hB000);
    check("w98_crc", fw_obs[98], frame_crc(12'd0, 12'd0));
    check("w99", fw_obs[99], 16'hC000);
    step(1'b0, 7'd0, 1'b0, 1'b1, 16'h0000);
    check("eoe", last_tx, 16'hF7F7);
    check("frm1", FRM_CNT, 12'd1);
    check("evt1", EVT_CNT, 12'd1);
    step(1'b0, 7'd0, 1'b0, 1'b0, 16'h0000);

    // Two frames back to back, no LAST_WRD
    do_reset();
    frame(-1);
    frame(-1);
    check("f2_w96", fw_obs[96], 16'hA001);
    check("f2_crc", fw_obs[98], frame_crc(12'd1, 12'd0));
    check("f2_evt", EVT_CNT, 12'd0);
    check("f2_frm", FRM_CNT, 12'd2);

    // Reset in the middle of a frame
    do_reset();
    step(1'b0, 7'd0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i <= 50; i++) step(1'b1, 7'(i), 1'b0, 1'b0, 16'(i));
    check("pre_rst_vld", TX_VLD, 1'b1);
    do_reset();
    frame(-1);
    check("post_rst_w96", fw_obs[96], 16'hA000);
    check("post_rst_crc", fw_obs[98], frame_crc(12'd0, 12'd0));

    // Sequence errors
    do_reset();
`ifdef CHNLNK_SEQ_CHECK_EN
    frame(40);
    check("skip_w99", fw_obs[99], 16'hC800);
    frame(-1);
    check("skip_sticky_w99", fw_obs[99], 16'hC800);
    check("skip_sticky", SEQ_ERR, 1'b1);
`else
    frame(-1);
    check("noerr_w99", fw_obs[99], 16'hC000);
    step(1'b1, 7'd100, 1'b0, 1'b0, 16'h1234);
    check("oor_data", last_tx, 16'h1234);
    check("oor_err", SEQ_ERR, 1'b1);
    frame(-1);
    check("oor_sticky_w99", fw_obs[99], 16'hC800);
`endif
    do_reset();
    check("err_cleared", SEQ_ERR, 1'b0);

    // Frame-counter wrap: preload 4095 trailer words
    for (int i = 0; i < 4095; i++) step(1'b1, 7'd99, 1'b0, 1'b0, 16'h0000);
    check("preload", FRM_CNT, 12'hFFF);
    frame(-1);
    check("wrap_w96", fw_obs[96], 16'hAFFF);
    check("wrap_cnt", FRM_CNT, 12'd0);
`ifdef CHNLNK_SEQ_CHECK_EN
    check("wrap_w99", fw_obs[99], 16'hC800);
`else
    check("wrap_w99", fw_obs[99], 16'hC000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chnlnk_frame_builder.md
Name: chnlnk_frame_builder

Overview:
- Sits directly downstream of the channel-link frame FSM in the DCFEB readout path.
- Consumes the FSM's VALID/SEQ/CLR_CRC/LAST_WRD strobes and the FIFO data word popped by RD.
- Builds the 100-word link frame: 96 data words, a frame-count word, an event-count word, a CRC-16 word and a trailer word.
- Outputs one registered 16-bit word plus K-flags per clock to the serializer, with comma idles between frames.

Parameters:
- DATA_WORDS, 96, number of payload words per frame (SEQ 0..95).
- IDLE_WORD, 16'h50BC, idle comma word (K28.5 in low byte).
- EOE_WORD, 16'hF7F7, end-of-event marker (K23.7 in both bytes).
- CRC_INIT, 16'hFFFF, CRC seed loaded on CLR_CRC.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- VALID  in  1  frame word strobe from frame FSM.
- SEQ  in  7  word index within frame, 0..99.
- CLR_CRC  in  1  re-seed CRC and sequence checker (FSM W4Data).
- LAST_WRD  in  1  end-of-event pulse (FSM Last_Word).
- DIN  in  16  FIFO output word; valid when VALID=1 and SEQ<96 (first-word-fall-through).
- TX_DATA  out  16  word to serializer.
- TX_K  out  2  per-byte K-char flags (bit0 = low byte).
- TX_VLD  out  1  1 while a frame word is on TX_DATA.
- FRM_CNT  out  12  frames completed, wraps.
- EVT_CNT  out  12  events completed, wraps.
- SEQ_ERR  out  1  sticky sequence error.

Behaviour:
- Reset (async, immediate):
  - TX_DATA=IDLE_WORD, TX_K=2'b01, TX_VLD=0.
  - CRC=CRC_INIT, FRM_CNT=0, EVT_CNT=0, SEQ_ERR=0, expected-seq=0.
- Latency: all TX_* outputs registered; input at cycle n appears on TX_* at cycle n+1.
- Word selection, priority order:
  - LAST_WRD=1 -> TX_DATA=EOE_WORD, TX_K=2'b11, TX_VLD=0.
  - VALID=1, SEQ<96 -> TX_DATA=DIN, TX_K=00, TX_VLD=1.
  - VALID=1, SEQ=96 -> {4'hA, FRM_CNT}, K=00, TX_VLD=1.
  - VALID=1, SEQ=97 -> {4'hB, EVT_CNT}, K=00, TX_VLD=1.
  - VALID=1, SEQ=98 -> CRC value accumulated over words 0..97, K=00, TX_VLD=1.
  - VALID=1, SEQ=99 -> {4'hC, SEQ_ERR, 11'h000}, K=00, TX_VLD=1.
  - VALID=1, SEQ>99 -> TX_DATA=DIN, TX_VLD=1, SEQ_ERR set.
  - Otherwise -> IDLE_WORD, K=01, TX_VLD=0.
- CRC:
  - CRC-16-CCITT, polynomial 0x1021, MSB-first, 16 bits per clock, no reflection, no final XOR.
  - Updated with the transmitted word for SEQ 0..97 only; held otherwise.
  - CLR_CRC loads CRC_INIT.
  - If CLR_CRC and VALID coincide: seed first, then accumulate the word from CRC_INIT.
- Counters:
  - FRM_CNT increments on the cycle after word SEQ=99 is accepted.
  - EVT_CNT increments on LAST_WRD.
  - Both are 12-bit and wrap 4095->0.
  - Words 96/97 carry the pre-increment values.
- Sequence tracking (see Optional Feature):
  - Expected-seq is cleared by CLR_CRC and after SEQ=99.
  - Advances by 1 on each VALID.
- Reset mid-frame: all state returns to reset values. The next frame must begin at SEQ=0 and is built normally.

Optional Feature:
- Macro: CHNLNK_SEQ_CHECK_EN.
- Defined:
  - On VALID with SEQ != expected-seq, SEQ_ERR sets and stays set until RST.
  - Expected-seq then resyncs to SEQ+1.
  - Duplicate, skipped or out-of-range indices all flag.
- Undefined:
  - Expected-seq logic omitted; SEQ_ERR set only by SEQ>99.
  - SEQ_ERR and the trailer error bit are otherwise tied 0.

Test Plan:
- Reset then idle 10 cycles -> TX_DATA=16'h50BC, TX_K=01, TX_VLD=0 every cycle; FRM_CNT=EVT_CNT=0.
- CLR_CRC, then full frame with DIN=SEQ (0..95), then LAST_WRD -> 100 words out with 1-cycle latency:
  - word96=16'hA000, word97=16'hB000, word99=16'hC000.
  - word98 equals bit-serial CCITT model over words 0..97.
  - EOE 16'hF7F7/K=11 follows; FRM_CNT=1, EVT_CNT=1.
- Two frames without LAST_WRD between them -> second word96=16'hA001, EVT_CNT stays 0, CRC re-seeded each frame.
- Preload 4095 frames -> word96=16'hAFFF, FRM_CNT wraps to 0 after word99.
- With CHNLNK_SEQ_CHECK_EN, skip SEQ=40 -> SEQ_ERR=1 from next cycle, word99=16'hC800, persists across frames until RST.
- Assert RST at SEQ=50 -> outputs return to idle same cycle; following frame's CRC matches model from CRC_INIT.
